// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants, FSM state type and arctangent table for
//                the iterative CORDIC sine engine. All fixed-point constants
//                are signed Q2.13 unless noted otherwise.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    // Build-time defaults for the engine
    localparam int DATA_W_DFLT = 16;
    localparam int GUARD_DFLT  = 2;
    localparam int ITER_DFLT   = 14;

    // Width of the internal x/y/z registers and of the atan table entries
    localparam int ATAN_W      = DATA_W_DFLT + GUARD_DFLT;

    // Iteration index width (covers up to 16 iterations)
    localparam int IDX_W       = 4;

    // Q2.13 constants
    localparam logic signed [DATA_W_DFLT-1:0] PI      = 16'sh6488;
    localparam logic signed [DATA_W_DFLT-1:0] HALF_PI = 16'sh3244;
    localparam logic signed [DATA_W_DFLT-1:0] ONE     = 16'sh2000;
    // CORDIC gain compensation 1/An, pre-loaded into x
    localparam logic signed [DATA_W_DFLT-1:0] K_INIT  = 16'sh136F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // atan(2^-i) in Q2.15 (13 fractional bits plus the guard bits)
    function automatic logic signed [ATAN_W-1:0] atan_lut(input logic [IDX_W-1:0] i);
        logic signed [ATAN_W-1:0] v;
        case (i)
            4'd0:    v = ATAN_W'(25736);
            4'd1:    v = ATAN_W'(15193);
            4'd2:    v = ATAN_W'(8027);
            4'd3:    v = ATAN_W'(4075);
            4'd4:    v = ATAN_W'(2045);
            4'd5:    v = ATAN_W'(1024);
            4'd6:    v = ATAN_W'(512);
            4'd7:    v = ATAN_W'(256);
            4'd8:    v = ATAN_W'(128);
            4'd9:    v = ATAN_W'(64);
            4'd10:   v = ATAN_W'(32);
            4'd11:   v = ATAN_W'(16);
            4'd12:   v = ATAN_W'(8);
            4'd13:   v = ATAN_W'(4);
            4'd14:   v = ATAN_W'(2);
            4'd15:   v = ATAN_W'(1);
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_atan_rom.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_atan_rom
//  Description : Combinational iteration-index to atan(2^-i) lookup feeding
//                the angle (z) accumulator of the CORDIC engine.
//  Ports       : i_idx  - iteration index
//                o_atan - atan(2^-i_idx), signed Q2.(13+guard)
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int OUT_W = ATAN_W
) (
    input  logic [IDX_W-1:0]        i_idx,
    output logic signed [OUT_W-1:0] o_atan
);

    assign o_atan = OUT_W'(atan_lut(i_idx));

endmodule
`default_nettype wire

// File: rtl/cordic_sine.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_sine
//  Description : Iterative rotation-mode CORDIC computing sin(Angle_i).
//                One rotation per clock, Start/Done handshake, one result
//                per request. Angles beyond +/-pi are clamped, angles beyond
//                +/-pi/2 are folded back into the convergence range.
//  Ports       : Clk_i   - clock, rising edge
//                Rst_i   - asynchronous reset, active low
//                Angle_i - signed angle in radians, Q2.13
//                Start_i - request, sampled only while idle
//                Sine_o  - signed sine, Q2.13, held until the next result
//                Cos_o   - signed cosine, Q2.13 (only with COS_OUT_EN)
//                Done_o  - one-cycle pulse, results valid
//  Options     : COS_OUT_EN - define to add the Cos_o output
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_sine
    import cordic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ITER   = ITER_DFLT,
    parameter int GUARD  = GUARD_DFLT
) (
    input  logic              Clk_i,
    input  logic              Rst_i,
    input  logic [DATA_W-1:0] Angle_i,
    input  logic              Start_i,
    output logic [DATA_W-1:0] Sine_o,
`ifdef COS_OUT_EN
    output logic [DATA_W-1:0] Cos_o,
`endif
    output logic              Done_o
);

    localparam int                       c_IW    = DATA_W + GUARD;
    localparam logic [IDX_W-1:0]         c_LAST  = IDX_W'(ITER - 1);
    localparam logic signed [c_IW-1:0]   c_K     = $signed({K_INIT, {GUARD{1'b0}}});
    localparam logic signed [c_IW:0]     c_RND   = (c_IW+1)'(1) <<< (GUARD - 1);
    localparam logic signed [c_IW:0]     c_ONE_W = (c_IW+1)'(ONE);

    state_t r_state;
    state_t w_state_nxt;
    logic   w_load;
    logic   w_step;
    logic   w_finish;

    logic signed [c_IW-1:0]   r_x;
    logic signed [c_IW-1:0]   r_y;
    logic signed [c_IW-1:0]   r_z;
    logic [IDX_W-1:0]         r_iter;
    logic signed [DATA_W-1:0] r_sine;
    logic                     r_done;

    logic signed [DATA_W-1:0] w_ang;
    logic signed [DATA_W-1:0] w_clamp;
    logic signed [DATA_W-1:0] w_z_fold;
    logic signed [c_IW-1:0]   w_z_init;
    logic signed [c_IW-1:0]   w_atan;
    logic signed [c_IW-1:0]   w_x_sh;
    logic signed [c_IW-1:0]   w_y_sh;
    logic signed [c_IW-1:0]   w_x_nxt;
    logic signed [c_IW-1:0]   w_y_nxt;
    logic signed [c_IW-1:0]   w_z_nxt;
    logic                     w_neg;

    // Drop the guard bits with round-half-up and clip to +/-1.0
    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [c_IW-1:0] v);
        logic signed [c_IW:0] t;
        logic signed [c_IW:0] sh;
        t  = {v[c_IW-1], v} + c_RND;
        sh = t >>> GUARD;
        if (sh > c_ONE_W) begin
            return DATA_W'(ONE);
        end else if (sh < -c_ONE_W) begin
            return -DATA_W'(ONE);
        end else begin
            return DATA_W'(sh);
        end
    endfunction

    // ------------------------------------------------------------------------
    // Input conditioning: clamp to +/-pi, then fold into +/-pi/2 using
    // sin(pi-a) = sin(a) and sin(-pi-a) = sin(a). No intermediate can leave
    // the DATA_W range once the clamp is applied.
    // ------------------------------------------------------------------------
    assign w_ang = Angle_i;

    always_comb begin
        w_clamp = w_ang;
        if (w_ang > PI) begin
            w_clamp = PI;
        end else if (w_ang < -PI) begin
            w_clamp = -PI;
        end

        w_z_fold = w_clamp;
        if (w_clamp > HALF_PI) begin
            w_z_fold = PI - w_clamp;
        end else if (w_clamp < -HALF_PI) begin
            w_z_fold = -PI - w_clamp;
        end
    end

    assign w_z_init = $signed({w_z_fold, {GUARD{1'b0}}});

    // ------------------------------------------------------------------------
    // Rotation step; both cross terms use the pre-update x and y.
    // z = 0 rotates in the positive direction.
    // ------------------------------------------------------------------------
    cordic_atan_rom #(
        .OUT_W (c_IW)
    ) u_atan_rom (
        .i_idx  (r_iter),
        .o_atan (w_atan)
    );

    assign w_neg   = r_z[c_IW-1];
    assign w_x_sh  = r_x >>> r_iter;
    assign w_y_sh  = r_y >>> r_iter;
    assign w_x_nxt = w_neg ? (r_x + w_y_sh) : (r_x - w_y_sh);
    assign w_y_nxt = w_neg ? (r_y - w_x_sh) : (r_y + w_x_sh);
    assign w_z_nxt = w_neg ? (r_z + w_atan) : (r_z - w_atan);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start_i) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ROTATE;
                end
            end
            ST_ROTATE: begin
                w_step = 1'b1;
                if (r_iter == c_LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and result registers. The result is captured on the edge that
    // leaves DONE, so Done_o is high for the first idle cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_iter <= '0;
            r_sine <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_x    <= c_K;
                r_y    <= '0;
                r_z    <= w_z_init;
                r_iter <= '0;
            end else if (w_step) begin
                r_x    <= w_x_nxt;
                r_y    <= w_y_nxt;
                r_z    <= w_z_nxt;
                r_iter <= r_iter + IDX_W'(1);
            end
            if (w_finish) begin
                r_sine <= round_sat(r_y);
            end
        end
    end

    assign Sine_o = r_sine;
    assign Done_o = r_done;

`ifdef COS_OUT_EN
    // Folding mirrors the angle across +/-pi/2, which flips the cosine sign
    logic                     w_fold;
    logic                     r_fold;
    logic signed [DATA_W-1:0] w_cos_abs;
    logic signed [DATA_W-1:0] r_cos;

    assign w_fold    = (w_clamp > HALF_PI) || (w_clamp < -HALF_PI);
    assign w_cos_abs = round_sat(r_x);

    always_ff @(posedge Clk_i or negedge Rst_i) begin
        if (!Rst_i) begin
            r_fold <= 1'b0;
            r_cos  <= '0;
        end else begin
            if (w_load) begin
                r_fold <= w_fold;
            end
            if (w_finish) begin
                r_cos <= r_fold ? -w_cos_abs : w_cos_abs;
            end
        end
    end

    assign Cos_o = r_cos;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_sine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_sine
//  Description : Self-checking bench for cordic_sine. Results are compared
//                with a real-arithmetic sine of the clamped input angle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_sine;

    localparam int c_ITER = 14;
    localparam int c_TOL  = 4;
    localparam int c_PI_Q = 25736;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] angle = 16'h0000;
    logic [15:0] sine;
    logic        done;
`ifdef COS_OUT_EN
    logic [15:0] cos_v;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cordic_sine #(
        .DATA_W (16),
        .ITER   (c_ITER),
        .GUARD  (2)
    ) dut (
        .Clk_i   (clk),
        .Rst_i   (rst_n),
        .Angle_i (angle),
        .Start_i (start),
        .Sine_o  (sine),
`ifdef COS_OUT_EN
        .Cos_o   (cos_v),
`endif
        .Done_o  (done)
    );

    task automatic check(input string tag, input int obs, input int exp, input int tol);
        n_tests++;
        if (obs > exp + tol || obs < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    function automatic int clamp_ang(input logic [15:0] a);
        int v;
        v = int'($signed(a));
        if (v > c_PI_Q)  v = c_PI_Q;
        if (v < -c_PI_Q) v = -c_PI_Q;
        return v;
    endfunction

    function automatic int ref_sin(input logic [15:0] a);
        real r;
        r = $sin(real'(clamp_ang(a)) / 8192.0);
        return $rtoi($floor(r * 8192.0 + 0.5));
    endfunction

    function automatic int ref_cos(input logic [15:0] a);
        real r;
        r = $cos(real'(clamp_ang(a)) / 8192.0);
        return $rtoi($floor(r * 8192.0 + 0.5));
    endfunction

    // One request: Start held for 'hold' cycles; optionally scramble Angle_i
    // and Start_i while the engine is busy.
    task automatic run(input logic [15:0] a, input int hold, input bit perturb, input string tag);
        int lat;
        int ndone;
        lat   = 0;
        ndone = 0;
        @(negedge clk);
        angle = a;
        start = 1'b1;
        for (int c = 1; c <= c_ITER + 6; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = c;
                    check({tag, ".sine"}, int'($signed(sine)), ref_sin(a), c_TOL);
`ifdef COS_OUT_EN
                    check({tag, ".cos"}, int'($signed(cos_v)), ref_cos(a), c_TOL);
`endif
                end
            end
            if (perturb && c <= c_ITER) begin
                angle = 16'($urandom);
                start = 1'($urandom);
            end else if (c >= hold) begin
                start = 1'b0;
            end
        end
        check({tag, ".latency"}, lat, c_ITER + 2, 0);
        check({tag, ".pulses"}, ndone, 1, 0);
        check({tag, ".held"}, int'($signed(sine)), ref_sin(a), c_TOL);
    endtask

    initial begin : main
        int ndone;
        int nz;
        int t_first;
        int t_second;

        // Reset and idle behaviour
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.sine", int'(sine), 0, 0);
        check("reset.done", int'(done), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        nz    = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
            if (sine != 16'h0000) nz++;
        end
        check("idle.done_count", ndone, 0, 0);
        check("idle.sine_nonzero", nz, 0, 0);

        // Directed angles
        run(16'h10C1, 2, 1'b0, "deg30");
        run(16'h1999, 1, 1'b0, "rad0p8");
        run(16'h0000, 1, 1'b0, "zero");
        run(16'h6488, 1, 1'b0, "pi");
        run(16'hCDBC, 1, 1'b0, "neg_half_pi");
        run(16'h7FFF, 1, 1'b0, "clamp_pos");
        run(16'h8000, 1, 1'b0, "clamp_neg");
        run(16'h3244, 3, 1'b0, "half_pi");
        run(16'hA000, 1, 1'b0, "fold_neg");

        // Inputs scrambled while busy
        run(16'h1999, 1, 1'b1, "ignore_busy");

        // Back-to-back requests with Start held high
        t_first  = 0;
        t_second = 0;
        @(negedge clk);
        angle = 16'h2000;
        start = 1'b1;
        for (int c = 1; c <= 2 * (c_ITER + 2) + 4; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (t_first == 0) t_first = c;
                else if (t_second == 0) t_second = c;
            end
        end
        start = 1'b0;
        check("b2b.first", t_first, c_ITER + 2, 0);
        check("b2b.period", t_second - t_first, c_ITER + 2, 0);
        check("b2b.sine", int'($signed(sine)), ref_sin(16'h2000), c_TOL);
        repeat (c_ITER + 6) @(posedge clk);

        // Reset in the middle of a rotation
        @(negedge clk);
        angle = 16'h1999;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.sine", int'(sine), 0, 0);
        check("abort.done", int'(done), 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < c_ITER + 6; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort.no_done", ndone, 0, 0);
        run(16'hF000, 1, 1'b0, "after_abort");

        // Random angles over the full input range
        for (int n = 0; n < 25; n++) begin
            run(16'($urandom), int'($urandom_range(1, 3)), 1'($urandom), $sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
